// File: rtl/branch_predictor.sv
// Fetch-side BTB/BHT next-PC prediction and execute-side JAL/JALR/BRANCH resolution with table training.
// Latency: lookup and resolution are combinational; table and counter updates land on the next clock edge.
// Backpressure: none; one lookup and one resolution are accepted every cycle, gated only by i_ex_valid.
module branch_predictor #(
    parameter int XLEN        = 32,
    parameter int BHT_ENTRIES = 64,
    parameter int BTB_ENTRIES = 16,
    parameter int CNT_W       = 32
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic [XLEN-1:0]   i_if_pc,
    output logic              o_if_pred_taken,
    output logic [XLEN-1:0]   o_if_pred_pc,
    input  logic              i_ex_valid,
    input  logic [6:0]        i_ex_opcode,
    input  logic [2:0]        i_ex_funct3,
    input  logic              i_ex_alu_zero,
    input  logic [XLEN-1:0]   i_ex_pc,
    input  logic [31:0]       i_ex_rs1_dout,
    input  logic [31:0]       i_ex_imm,
    input  logic              i_ex_pred_taken,
    input  logic [XLEN-1:0]   i_ex_pred_pc,
    output logic              o_ex_branch_taken,
    output logic              o_ex_mispredict,
    output logic [XLEN-1:0]   o_ex_pc_redirect,
    output logic [CNT_W-1:0]  o_br_count,
    output logic [CNT_W-1:0]  o_mispred_count
);
    localparam int BHT_IDX_W = $clog2(BHT_ENTRIES);
    localparam int BTB_IDX_W = $clog2(BTB_ENTRIES);
    localparam int TAG_W     = XLEN - BTB_IDX_W - 2;

    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    logic [BHT_ENTRIES-1:0][1:0] bht_q;
    logic [BTB_ENTRIES-1:0]      btb_vld_q;
    logic [BTB_ENTRIES-1:0]      btb_jmp_q;
    logic [TAG_W-1:0]            btb_tag_q [BTB_ENTRIES];
    logic [XLEN-1:0]             btb_tgt_q [BTB_ENTRIES];
    logic [CNT_W-1:0]            br_cnt_q;
    logic [CNT_W-1:0]            mp_cnt_q;

    // ---------------- fetch lookup ----------------
    logic [BHT_IDX_W-1:0] if_bht_idx;
    logic [BTB_IDX_W-1:0] if_btb_idx;
    logic [TAG_W-1:0]     if_tag;
    logic                 if_hit;

    assign if_bht_idx      = i_if_pc[BHT_IDX_W+1:2];
    assign if_btb_idx      = i_if_pc[BTB_IDX_W+1:2];
    assign if_tag          = i_if_pc[XLEN-1:BTB_IDX_W+2];
    assign if_hit          = btb_vld_q[if_btb_idx] && (btb_tag_q[if_btb_idx] == if_tag);
    assign o_if_pred_taken = if_hit && (btb_jmp_q[if_btb_idx] || bht_q[if_bht_idx][1]);
    assign o_if_pred_pc    = o_if_pred_taken ? btb_tgt_q[if_btb_idx] : i_if_pc + XLEN'(4);

    // ---------------- execute resolution ----------------
    logic [XLEN-1:0] imm_x;
    logic [XLEN-1:0] pc_imm;
    logic [XLEN-1:0] jalr_sum;
    logic [XLEN-1:0] seq_pc;
    logic [XLEN-1:0] target;
    logic [XLEN-1:0] next_pc;
    logic            is_ctrl;
    logic            is_jump;
    logic            is_br;
    logic            taken;
    logic            mispredict;

    assign imm_x    = XLEN'($signed(i_ex_imm));
    assign pc_imm   = i_ex_pc + imm_x;
    assign jalr_sum = XLEN'(i_ex_rs1_dout) + imm_x;
    assign seq_pc   = i_ex_pc + XLEN'(4);

    always_comb begin
        is_ctrl = 1'b0;
        is_jump = 1'b0;
        is_br   = 1'b0;
        taken   = 1'b0;
        target  = pc_imm;
        case (i_ex_opcode)
            OP_JAL: begin
                is_ctrl = 1'b1;
                is_jump = 1'b1;
                taken   = 1'b1;
            end
            OP_JALR: begin
                if (i_ex_funct3 == 3'b000) begin
                    is_ctrl = 1'b1;
                    is_jump = 1'b1;
                    taken   = 1'b1;
                    target  = {jalr_sum[XLEN-1:1], 1'b0};
                end
            end
            OP_BRANCH: begin
                if (i_ex_funct3 != 3'b010 && i_ex_funct3 != 3'b011) begin
                    is_ctrl = 1'b1;
                    is_br   = 1'b1;
                    // BNE/BLT/BLTU invert the zero flag; BEQ/BGE/BGEU use it directly
                    taken   = i_ex_alu_zero ^ (i_ex_funct3[2] ^ i_ex_funct3[0]);
                end
            end
            default: ;
        endcase
    end

    assign next_pc    = taken ? target : seq_pc;
    assign mispredict = (i_ex_pred_taken != taken) || (taken && (i_ex_pred_pc != target));

    assign o_ex_branch_taken = i_ex_valid && taken;
    assign o_ex_mispredict   = i_ex_valid && mispredict;
    assign o_ex_pc_redirect  = i_ex_valid ? next_pc : '0;
    assign o_br_count        = br_cnt_q;
    assign o_mispred_count   = mp_cnt_q;

    // ---------------- training ----------------
    logic [BHT_IDX_W-1:0] ex_bht_idx;
    logic [BTB_IDX_W-1:0] ex_btb_idx;
    logic [TAG_W-1:0]     ex_tag;
    logic                 ex_hit;
    logic                 btb_wr;
    logic [1:0]           bht_cur;
    logic [1:0]           bht_nxt;

    assign ex_bht_idx = i_ex_pc[BHT_IDX_W+1:2];
    assign ex_btb_idx = i_ex_pc[BTB_IDX_W+1:2];
    assign ex_tag     = i_ex_pc[XLEN-1:BTB_IDX_W+2];
    assign ex_hit     = btb_vld_q[ex_btb_idx] && (btb_tag_q[ex_btb_idx] == ex_tag);
    assign btb_wr     = is_jump || (is_br && taken);
    assign bht_cur    = bht_q[ex_bht_idx];

    always_comb begin
        bht_nxt = bht_cur;
        if (taken) begin
            if (bht_cur != 2'b11) bht_nxt = bht_cur + 2'd1;
        end else begin
            if (bht_cur != 2'b00) bht_nxt = bht_cur - 2'd1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            bht_q     <= {BHT_ENTRIES{2'b01}};
            btb_vld_q <= '0;
            br_cnt_q  <= '0;
            mp_cnt_q  <= '0;
        end else if (i_ex_valid) begin
            if (is_br) bht_q[ex_bht_idx] <= bht_nxt;
            if (btb_wr) begin
                btb_vld_q[ex_btb_idx] <= 1'b1;
            end else if (!is_ctrl && ex_hit) begin
                // a non-control instruction aliased into a stale entry: drop it
                btb_vld_q[ex_btb_idx] <= 1'b0;
            end
            if (is_ctrl)    br_cnt_q <= br_cnt_q + CNT_W'(1);
            if (mispredict) mp_cnt_q <= mp_cnt_q + CNT_W'(1);
        end
    end

    // Payload fields need no reset; the valid bits guard them.
    always_ff @(posedge i_clk) begin
        if (i_rst_n && i_ex_valid && btb_wr) begin
            btb_tag_q[ex_btb_idx] <= ex_tag;
            btb_tgt_q[ex_btb_idx] <= target;
            btb_jmp_q[ex_btb_idx] <= is_jump;
        end
    end

endmodule

// File: tb/tb_branch_predictor.sv
// Directed plus randomized bench for branch_predictor against a table-level reference model.
module tb_branch_predictor;
    localparam logic [6:0] OP_BR   = 7'h63;
    localparam logic [6:0] OP_JALR = 7'h67;
    localparam logic [6:0] OP_JAL  = 7'h6F;
    localparam logic [6:0] OP_ADD  = 7'h33;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] if_pc;
    logic        if_pred_taken;
    logic [31:0] if_pred_pc;
    logic        ex_valid;
    logic [6:0]  ex_opcode;
    logic [2:0]  ex_funct3;
    logic        ex_alu_zero;
    logic [31:0] ex_pc;
    logic [31:0] ex_rs1;
    logic [31:0] ex_imm;
    logic        ex_pred_taken;
    logic [31:0] ex_pred_pc;
    logic        ex_branch_taken;
    logic        ex_mispredict;
    logic [31:0] ex_pc_redirect;
    logic [31:0] br_count;
    logic [31:0] mispred_count;

    always #5 clk = ~clk;

    branch_predictor dut (
        .i_clk            (clk),
        .i_rst_n          (rst_n),
        .i_if_pc          (if_pc),
        .o_if_pred_taken  (if_pred_taken),
        .o_if_pred_pc     (if_pred_pc),
        .i_ex_valid       (ex_valid),
        .i_ex_opcode      (ex_opcode),
        .i_ex_funct3      (ex_funct3),
        .i_ex_alu_zero    (ex_alu_zero),
        .i_ex_pc          (ex_pc),
        .i_ex_rs1_dout    (ex_rs1),
        .i_ex_imm         (ex_imm),
        .i_ex_pred_taken  (ex_pred_taken),
        .i_ex_pred_pc     (ex_pred_pc),
        .o_ex_branch_taken(ex_branch_taken),
        .o_ex_mispredict  (ex_mispredict),
        .o_ex_pc_redirect (ex_pc_redirect),
        .o_br_count       (br_count),
        .o_mispred_count  (mispred_count)
    );

    // reference model: saturating counters as ints, BTB as plain arrays
    int          m_bht [64];
    bit          m_vld [16];
    logic [31:0] m_tag [16];
    logic [31:0] m_tgt [16];
    bit          m_jmp [16];
    int          m_br;
    int          m_mp;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic m_reset();
        for (int i = 0; i < 64; i++) m_bht[i] = 1;
        for (int i = 0; i < 16; i++) m_vld[i] = 1'b0;
        m_br = 0;
        m_mp = 0;
    endtask

    task automatic m_predict(input logic [31:0] pc, output bit t, output logic [31:0] npc);
        int  bi = (pc / 4) % 64;
        int  ti = (pc / 4) % 16;
        bit  hit = m_vld[ti] && (m_tag[ti] == pc / 64);
        t   = hit && (m_jmp[ti] || m_bht[bi] >= 2);
        npc = t ? m_tgt[ti] : pc + 32'd4;
    endtask

    task automatic m_resolve(input logic [6:0] op, input logic [2:0] f3, input bit z,
                             input logic [31:0] pc, input logic [31:0] rs1, input logic [31:0] imm,
                             output bit ctrl, output bit jump, output bit tk, output logic [31:0] tgt);
        ctrl = 0; jump = 0; tk = 0; tgt = pc + imm;
        if (op == OP_JAL) begin
            ctrl = 1; jump = 1; tk = 1;
        end else if (op == OP_JALR && f3 == 3'd0) begin
            ctrl = 1; jump = 1; tk = 1;
            tgt = (rs1 + imm) & 32'hFFFF_FFFE;
        end else if (op == OP_BR) begin
            ctrl = 1;
            case (f3)
                3'd0, 3'd5, 3'd7: tk = z;     // BEQ, BGE, BGEU
                3'd1, 3'd4, 3'd6: tk = !z;    // BNE, BLT, BLTU
                default: ctrl = 0;
            endcase
        end
    endtask

    // Drive one cycle at the negedge, check combinational outputs, then advance the model at the posedge.
    task automatic step(input logic [31:0] ipc, input bit rst, input bit vld,
                        input logic [6:0] op, input logic [2:0] f3, input bit z,
                        input logic [31:0] pc, input logic [31:0] rs1, input logic [31:0] imm,
                        input bit pt, input logic [31:0] ppc);
        bit          et, ctrl, jump, tk, mp, hit;
        logic [31:0] epc, tgt, nxt;
        int          bi, ti;
        rst_n = rst; if_pc = ipc; ex_valid = vld; ex_opcode = op; ex_funct3 = f3;
        ex_alu_zero = z; ex_pc = pc; ex_rs1 = rs1; ex_imm = imm;
        ex_pred_taken = pt; ex_pred_pc = ppc;
        #1;
        m_predict(ipc, et, epc);
        m_resolve(op, f3, z, pc, rs1, imm, ctrl, jump, tk, tgt);
        nxt = tk ? tgt : pc + 32'd4;
        mp  = (pt != tk) || (tk && ppc != tgt);
        chk("pred_taken", 32'(if_pred_taken), 32'(et));
        chk("pred_pc", if_pred_pc, epc);
        chk("branch_taken", 32'(ex_branch_taken), 32'(vld && tk));
        chk("mispredict", 32'(ex_mispredict), 32'(vld && mp));
        chk("pc_redirect", ex_pc_redirect, vld ? nxt : 32'd0);
        chk("br_count", br_count, 32'(m_br));
        chk("mispred_count", mispred_count, 32'(m_mp));
        @(posedge clk);
        if (!rst) begin
            m_reset();
        end else if (vld) begin
            bi  = (pc / 4) % 64;
            ti  = (pc / 4) % 16;
            hit = m_vld[ti] && (m_tag[ti] == pc / 64);
            if (ctrl && !jump) m_bht[bi] = tk ? ((m_bht[bi] < 3) ? m_bht[bi] + 1 : 3)
                                              : ((m_bht[bi] > 0) ? m_bht[bi] - 1 : 0);
            if (jump || (ctrl && tk)) begin
                m_vld[ti] = 1'b1; m_tag[ti] = pc / 64; m_tgt[ti] = tgt; m_jmp[ti] = jump;
            end else if (!ctrl && hit) begin
                m_vld[ti] = 1'b0;
            end
            if (ctrl) m_br++;
            if (mp)   m_mp++;
        end
        @(negedge clk);
        #1;
    endtask

    initial begin
        bit          pt;
        logic [31:0] ppc, pc, ipc;
        logic [6:0]  op;
        int          sel;

        rst_n = 1'b0; if_pc = 32'h100; ex_valid = 1'b0; ex_opcode = OP_ADD; ex_funct3 = 3'd0;
        ex_alu_zero = 1'b0; ex_pc = 32'h0; ex_rs1 = 32'h0; ex_imm = 32'h0;
        ex_pred_taken = 1'b0; ex_pred_pc = 32'h0;
        m_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);

        // reset state
        step(32'h100, 1, 0, OP_ADD, 3'd0, 0, 32'h0, 32'h0, 32'h0, 0, 32'h0);
        chk("rst_pred_taken", 32'(if_pred_taken), 32'd0);
        chk("rst_pred_pc", if_pred_pc, 32'h104);
        chk("rst_br_count", br_count, 32'd0);
        chk("rst_redirect", ex_pc_redirect, 32'd0);

        // BEQ taken, unpredicted: counter 01->10, BTB filled
        step(32'h100, 1, 1, OP_BR, 3'd0, 1, 32'h100, 32'h0, 32'h40, 0, 32'h104);
        chk("beq_lookup_taken", 32'(if_pred_taken), 32'd1);
        chk("beq_lookup_pc", if_pred_pc, 32'h140);
        // two not-taken: 10->01->00
        step(32'h100, 1, 1, OP_BR, 3'd0, 0, 32'h100, 32'h0, 32'h40, 1, 32'h140);
        step(32'h100, 1, 1, OP_BR, 3'd0, 0, 32'h100, 32'h0, 32'h40, 0, 32'h104);
        chk("beq_nt_pc", if_pred_pc, 32'h104);
        // saturation at 00: one taken only reaches 01, still predicted not taken
        step(32'h100, 1, 1, OP_BR, 3'd0, 0, 32'h100, 32'h0, 32'h40, 0, 32'h104);
        step(32'h100, 1, 1, OP_BR, 3'd0, 1, 32'h100, 32'h0, 32'h40, 0, 32'h104);
        chk("beq_sat_taken", 32'(if_pred_taken), 32'd0);

        // JALR correctly predicted, bit 0 of target cleared
        step(32'h200, 1, 1, OP_JALR, 3'd0, 0, 32'h200, 32'h2001, 32'h4, 1, 32'h2004);
        chk("jalr_lookup_pc", if_pred_pc, 32'h2004);
        // JALR funct3!=0 is non-control
        step(32'h240, 1, 1, OP_JALR, 3'd1, 0, 32'h240, 32'h2001, 32'h4, 0, 32'h244);
        chk("jalr_f3_brcount", br_count, 32'd6);
        chk("jalr_f3_mpcount", mispred_count, 32'd3);
        chk("jalr_f3_lookup", 32'(if_pred_taken), 32'd0);

        // aliasing: JAL fills 0x180, then an ADD there invalidates it
        step(32'h180, 1, 1, OP_JAL, 3'd0, 0, 32'h180, 32'h0, 32'h80, 0, 32'h184);
        step(32'h180, 1, 1, OP_ADD, 3'd0, 0, 32'h180, 32'h0, 32'h0, 1, 32'h200);
        chk("alias_redirect", ex_pc_redirect, 32'h184);
        chk("alias_invalidated", 32'(if_pred_taken), 32'd0);
        // JAL target wraps past 2^32
        step(32'h0, 1, 1, OP_JAL, 3'd0, 0, 32'hFFFF_FFFC, 32'h0, 32'h8, 0, 32'h0);
        chk("jal_wrap_redirect", ex_pc_redirect, 32'h4);

        // reset coinciding with a taken branch update
        step(32'h300, 0, 1, OP_BR, 3'd0, 1, 32'h300, 32'h0, 32'h40, 0, 32'h304);
        chk("rst_update_lookup", 32'(if_pred_taken), 32'd0);
        chk("rst_update_brcount", br_count, 32'd0);
        chk("rst_update_mpcount", mispred_count, 32'd0);

        // randomized traffic over a small PC pool so BTB/BHT entries collide
        for (int n = 0; n < 600; n++) begin
            pc  = 32'h100 + 32'(4 * $urandom_range(0, 63));
            ipc = ($urandom_range(0, 1) == 1) ? pc : 32'h100 + 32'(4 * $urandom_range(0, 63));
            sel = $urandom_range(0, 3);
            op  = (sel == 0) ? OP_JAL : (sel == 1) ? OP_JALR : (sel == 2) ? OP_BR : OP_ADD;
            if ($urandom_range(0, 2) != 0) begin
                m_predict(pc, pt, ppc);
            end else begin
                pt  = 1'($urandom_range(0, 1));
                ppc = 32'h100 + 32'(4 * $urandom_range(0, 63));
            end
            step(ipc, $urandom_range(0, 63) != 0, $urandom_range(0, 7) != 0, op,
                 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), pc,
                 ($urandom_range(0, 1) == 1) ? pc + 32'h41 : $urandom,
                 32'(4 * $urandom_range(0, 31)) - 32'd64, pt, ppc);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
